// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit types, FSM states and nine's-complement helper
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Wraps mod 16 for non-BCD inputs; such digits are deliberately not corrected.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return bcd_digit_t'(bcd_digit_t'(BCD_MAX) - d);
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// rtl/bcd_digit_addsub.sv - combinational single-digit BCD add/subtract core
module bcd_digit_addsub
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    input  logic       sub,
    output bcd_digit_t d,
    output logic       cout
);

    bcd_digit_t w_b;
    logic [4:0] w_sum;

    assign w_b   = sub ? nines_comp(b) : b;
    assign w_sum = {1'b0, a} + {1'b0, w_b} + {4'b0000, cin};
    assign cout  = (w_sum > 5'(BCD_MAX));
    assign d     = cout ? bcd_digit_t'(w_sum - 5'd10) : w_sum[3:0];

endmodule

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - digit-serial BCD adder/subtractor; optional BCD_CHECK_EN flags non-BCD operands
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WIDTH  = BCD_DIGIT_W * DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             carry,
    output logic             err
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DIGITS - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_y;
    logic               r_op;
    logic               r_c;
    logic [CNT_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_z;
    logic               r_carry;

    logic               w_accept;
    logic               w_last;
    bcd_digit_t         w_a;
    bcd_digit_t         w_b;
    bcd_digit_t         w_d;
    logic               w_cout;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_a      = r_x[{r_idx, 2'b00} +: BCD_DIGIT_W];
    assign w_b      = r_y[{r_idx, 2'b00} +: BCD_DIGIT_W];

    bcd_digit_addsub u_digit (
        .a    (w_a),
        .b    (w_b),
        .cin  (r_c),
        .sub  (r_op),
        .d    (w_d),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                // Gated by rst_n so the block never advertises readiness while held in reset.
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_op    <= 1'b0;
            r_c     <= 1'b0;
            r_idx   <= '0;
            r_z     <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x     <= x;
                        r_y     <= y;
                        r_op    <= op;
                        r_c     <= op;
                        r_idx   <= '0;
                        r_z     <= '0;
                        r_carry <= 1'b0;
                    end
                end
                RUN: begin
                    r_z[{r_idx, 2'b00} +: BCD_DIGIT_W] <= w_d;
                    r_c   <= w_cout;
                    r_idx <= w_last ? '0 : r_idx + 1'b1;
                    if (w_last) begin
                        // For subtract, no carry out of the top digit means a borrow.
                        r_carry <= r_op ? ~w_cout : w_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign z     = r_z;
    assign carry = r_carry;

`ifdef BCD_CHECK_EN
    logic r_err;

    function automatic logic has_non_bcd(input logic [WIDTH-1:0] v);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] > bcd_digit_t'(BCD_MAX)) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= has_non_bcd(x) || has_non_bcd(y);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb/tb_bcd_serial_addsub.sv - directed self-checking bench for bcd_serial_addsub (DIGITS=4)
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int WIDTH  = 4 * DIGITS;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] z;
    logic             carry;
    logic             err;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef BCD_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .carry     (carry),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic op_i, input logic [WIDTH-1:0] x_i, input logic [WIDTH-1:0] y_i);
        in_valid = 1'b1;
        op       = op_i;
        x        = x_i;
        y        = y_i;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic op_i,
                          input logic [WIDTH-1:0] x_i, input logic [WIDTH-1:0] y_i,
                          input logic [WIDTH-1:0] z_exp, input logic c_exp, input logic e_exp);
        int lat;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        start_op(op_i, x_i, y_i);
        wait_done(lat);
        check({tag, "_latency"}, 32'(lat), 32'(DIGITS));
        check({tag, "_z"}, 32'(z), 32'(z_exp));
        check({tag, "_carry"}, 32'(carry), 32'(c_exp));
        check({tag, "_err"}, 32'(err), 32'(e_exp));
        handshake();
        check({tag, "_done_cleared"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int               lat;
        logic [WIDTH-1:0] z_hold;
        logic             c_hold;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 1'b0;
        x         = '0;
        y         = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        run_op("add",      1'b0, 16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0);
        run_op("add_ovf",  1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op("sub_pos",  1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0, 1'b0);
        run_op("sub_neg",  1'b1, 16'h1234, 16'h5000, 16'h6234, 1'b1, 1'b0);
        run_op("sub_zero", 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        run_op("sub_m1",   1'b1, 16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0);

        // Backpressure: DONE holds with out_ready low while in_valid pulses are ignored.
        start_op(1'b0, 16'h0042, 16'h0058);
        wait_done(lat);
        check("bp_latency", 32'(lat), 32'(DIGITS));
        z_hold = z;
        c_hold = carry;
        check("bp_z", 32'(z_hold), 32'h0100);
        check("bp_carry", 32'(c_hold), 32'd0);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            x        = 16'h7777;
            y        = 16'h1111;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_z_stable", 32'(z), 32'h0100);
            check("bp_carry_stable", 32'(carry), 32'd0);
        end
        handshake();
        check("bp_in_ready_after", 32'(in_ready), 32'd1);
        check("bp_out_valid_after", 32'(out_valid), 32'd0);
        repeat (DIGITS + 1) @(posedge clk);
        #1;
        check("bp_no_ghost_op", 32'(out_valid), 32'd0);

        // out_ready held high while nothing is valid must not disturb the next op.
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stray_ready_in_ready", 32'(in_ready), 32'd1);

        // Reset two cycles into RUN discards the partial result.
        start_op(1'b0, 16'h9999, 16'h9999);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_z", 32'(z), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready_after", 32'(in_ready), 32'd1);
        check("midrst_z_after", 32'(z), 32'd0);
        run_op("post_rst", 1'b0, 16'h0005, 16'h0005, 16'h0010, 1'b0, 1'b0);

        // Non-BCD digit: arithmetic proceeds mod 16; err raised only when the checker is built.
        run_op("nonbcd",   1'b0, 16'h00A1, 16'h0001, 16'h0102, 1'b0, ERR_EXP);
        run_op("err_clr",  1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
